// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with almost-full/empty thresholds, occupancy count, sticky ovf/udf, sync flush.
// Latency: a write is visible the next cycle; rdata is registered (1 cycle) or first-word fall-through if FIFO_FWFT_EN.
// Backpressure: full drops writes and sets ovf, empty drops reads and sets udf; gating uses registered state only.
module sync_fifo #(
   parameter int DW        = 8,
   parameter int AW        = 3,
   parameter int AFULL_TH  = 6,
   parameter int AEMPTY_TH = 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          clr,
   input  logic          wreq,
   input  logic [DW-1:0] wdata,
   output logic          full,
   output logic          afull,
   input  logic          rreq,
   output logic [DW-1:0] rdata,
   output logic          empty,
   output logic          aempty,
   output logic [AW:0]   level,
   output logic          ovf,
   output logic          udf
);

   localparam int          DEPTH    = 2 ** AW;
   localparam logic [AW:0] DEPTH_L  = DEPTH[AW:0];
   localparam logic [AW:0] AFULL_L  = AFULL_TH[AW:0];
   localparam logic [AW:0] AEMPTY_L = AEMPTY_TH[AW:0];

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_w;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          full_w, empty_w;
   logic          wr_acc, rd_acc;

   // Wrap bit in the pointer MSB makes the modulo difference the exact occupancy.
   assign level_w = wr_ptr_q - rd_ptr_q;
   assign full_w  = (level_w == DEPTH_L);
   assign empty_w = (level_w == '0);
   assign wr_acc  = wreq & ~full_w & ~clr;
   assign rd_acc  = rreq & ~empty_w & ~clr;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (wr_acc)         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (rd_acc)         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
         if (wreq & full_w)  ovf_d    = 1'b1;
         if (rreq & empty_w) udf_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage carries no reset; stale words are never exposed because empty gates every read path.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

`ifdef FIFO_FWFT_EN
   assign rdata = empty_w ? '0 : mem_q[rd_ptr_q[AW-1:0]];
`else
   logic [DW-1:0] rdata_q, rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (clr)         rdata_d = '0;
      else if (rd_acc) rdata_d = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) rdata_q <= '0;
      else       rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;
`endif

   assign level  = level_w;
   assign full   = full_w;
   assign empty  = empty_w;
   assign afull  = (level_w >= AFULL_L);
   assign aempty = (level_w <= AEMPTY_L);
   assign ovf    = ovf_q;
   assign udf    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo (DW=8, AW=3): directed scenarios plus random traffic against a queue model.
module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       rstn, clr, wreq, rreq;
   logic [7:0] wdata, rdata;
   logic       full, afull, empty, aempty, ovf, udf;
   logic [3:0] level;

   int cmp = 0;
   int bad = 0;

   logic [7:0] q [$];
   bit         m_ovf, m_udf;
   logic [7:0] m_rdata;

   wire [9:0] act_st = {full, afull, empty, aempty, ovf, udf, level};
   localparam logic [9:0] RST_ST = 10'b0011000000;

   sync_fifo #(.DW(8), .AW(3), .AFULL_TH(6), .AEMPTY_TH(1)) dut (
      .clk(clk), .rstn(rstn), .clr(clr), .wreq(wreq), .wdata(wdata),
      .full(full), .afull(afull), .rreq(rreq), .rdata(rdata),
      .empty(empty), .aempty(aempty), .level(level), .ovf(ovf), .udf(udf)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] exp_status();
      int n = q.size();
      return {n == 8, n >= 6, n == 0, n <= 1, m_ovf, m_udf, 4'(n)};
   endfunction

   function automatic logic [7:0] exp_rdata();
`ifdef FIFO_FWFT_EN
      return (q.size() != 0) ? q[0] : 8'h00;
`else
      return m_rdata;
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_rdata = 8'h00;
   endtask

   // Drive one cycle from a negedge, apply the FIFO rules to the model, return at the next negedge.
   task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit c);
      bit was_full, was_empty;
      wreq = w; wdata = d; rreq = r; clr = c;
      @(posedge clk);
      was_full  = (q.size() == 8);
      was_empty = (q.size() == 0);
      if (c) model_reset();
      else begin
         if (r && was_empty) m_udf = 1'b1;
         else if (r)         m_rdata = q.pop_front();
         if (w && was_full)  m_ovf = 1'b1;
         else if (w)         q.push_back(d);
      end
      @(negedge clk);
      wreq = 1'b0; rreq = 1'b0; clr = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; clr = 1'b0; wreq = 1'b0; rreq = 1'b0; wdata = 8'h00;
      model_reset();
      repeat (2) @(negedge clk);
      cmp++; if (act_st !== RST_ST) begin bad++; $display("FAIL reset_status got=%b exp=%b", act_st, RST_ST); end
      cmp++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fill_drain();
      cyc(0, 8'h00, 0, 1);
      for (int i = 0; i < 8; i++) begin
         cyc(1, 8'(i), 0, 0);
         cmp++; if (act_st !== exp_status()) begin bad++; $display("FAIL fill_status i=%0d got=%b exp=%b", i, act_st, exp_status()); end
      end
      cmp++; if (level !== 4'd8 || full !== 1'b1 || afull !== 1'b1) begin bad++; $display("FAIL fill_full got lvl=%0d full=%b afull=%b exp lvl=8 full=1 afull=1", level, full, afull); end
      for (int i = 0; i < 8; i++) begin
         cyc(0, 8'h00, 1, 0);
         cmp++; if (act_st !== exp_status()) begin bad++; $display("FAIL drain_status i=%0d got=%b exp=%b", i, act_st, exp_status()); end
         cmp++; if (rdata !== exp_rdata()) begin bad++; $display("FAIL drain_rdata i=%0d got=%h exp=%h", i, rdata, exp_rdata()); end
      end
      cmp++; if (empty !== 1'b1 || aempty !== 1'b1) begin bad++; $display("FAIL drain_empty got empty=%b aempty=%b exp 1 1", empty, aempty); end
   endtask

   task automatic test_overflow();
      cyc(0, 8'h00, 0, 1);
      for (int i = 0; i < 8; i++) cyc(1, 8'h10 + 8'(i), 0, 0);
      cyc(1, 8'hAA, 0, 0);
      cmp++; if (ovf !== 1'b1 || level !== 4'd8) begin bad++; $display("FAIL ovf_set got ovf=%b lvl=%0d exp ovf=1 lvl=8", ovf, level); end
      for (int i = 0; i < 8; i++) begin
         cyc(0, 8'h00, 1, 0);
         cmp++; if (rdata !== exp_rdata()) begin bad++; $display("FAIL ovf_drain i=%0d got=%h exp=%h", i, rdata, exp_rdata()); end
      end
      cmp++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
      cyc(0, 8'h00, 0, 1);
      cmp++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
   endtask

   task automatic test_underflow();
      cyc(0, 8'h00, 0, 1);
      cyc(1, 8'h33, 0, 0);
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 1, 0);
      cmp++; if (act_st !== exp_status() || udf !== 1'b1) begin bad++; $display("FAIL udf_set got=%b exp=%b", act_st, exp_status()); end
      cmp++; if (rdata !== exp_rdata()) begin bad++; $display("FAIL udf_rdata got=%h exp=%h", rdata, exp_rdata()); end
      cyc(1, 8'h44, 1, 0);
      cmp++; if (level !== 4'd1 || udf !== 1'b1 || empty !== 1'b0) begin bad++; $display("FAIL udf_rw got lvl=%0d udf=%b empty=%b exp 1 1 0", level, udf, empty); end
      cmp++; if (rdata !== exp_rdata()) begin bad++; $display("FAIL udf_rw_rdata got=%h exp=%h", rdata, exp_rdata()); end
   endtask

   task automatic test_back_to_back();
      cyc(0, 8'h00, 0, 1);
      for (int i = 0; i < 4; i++) cyc(1, 8'(i), 0, 0);
      for (int k = 0; k < 20; k++) begin
         cyc(1, 8'(4 + k), 1, 0);
         cmp++; if (level !== 4'd4) begin bad++; $display("FAIL b2b_level k=%0d got=%0d exp=4", k, level); end
         cmp++; if (rdata !== exp_rdata()) begin bad++; $display("FAIL b2b_rdata k=%0d got=%h exp=%h", k, rdata, exp_rdata()); end
      end
   endtask

   task automatic test_clear();
      cyc(0, 8'h00, 0, 1);
      cyc(0, 8'h00, 1, 0);
      for (int i = 0; i < 5; i++) cyc(1, 8'h60 + 8'(i), 0, 0);
      cyc(0, 8'h00, 1, 0);
      cyc(1, 8'h77, 0, 0);
      cyc(1, 8'hEE, 1, 1);
      cmp++; if (act_st !== RST_ST) begin bad++; $display("FAIL clr_status got=%b exp=%b", act_st, RST_ST); end
      cmp++; if (rdata !== 8'h00) begin bad++; $display("FAIL clr_rdata got=%h exp=00", rdata); end
   endtask

   task automatic test_async_reset();
      cyc(0, 8'h00, 0, 1);
      cyc(0, 8'h00, 1, 0);
      for (int i = 0; i < 7; i++) cyc(1, 8'h21 + 8'(i), 0, 0);
      cyc(1, 8'h90, 1, 0);
      cyc(1, 8'h91, 0, 0);
      wreq = 1'b1; wdata = 8'h92;
      #2 rstn = 1'b0;
      #1;
      cmp++; if (act_st !== RST_ST) begin bad++; $display("FAIL arst_status got=%b exp=%b", act_st, RST_ST); end
      cmp++; if (rdata !== 8'h00) begin bad++; $display("FAIL arst_rdata got=%h exp=00", rdata); end
      wreq = 1'b0;
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      cmp++; if (act_st !== exp_status()) begin bad++; $display("FAIL arst_release got=%b exp=%b", act_st, exp_status()); end
   endtask

   task automatic test_random();
      bit w, r, c;
      for (int i = 0; i < 600; i++) begin
         if (((i / 60) % 2) == 0) begin
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) == 0);
         end else begin
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) != 0);
         end
         c = ($urandom_range(0, 49) == 0);
         cyc(w, 8'($urandom), r, c);
         cmp++; if (act_st !== exp_status()) begin bad++; $display("FAIL rand_status i=%0d got=%b exp=%b", i, act_st, exp_status()); end
         cmp++; if (rdata !== exp_rdata()) begin bad++; $display("FAIL rand_rdata i=%0d got=%h exp=%h", i, rdata, exp_rdata()); end
      end
   endtask

`ifdef FIFO_FWFT_EN
   task automatic test_fwft();
      cyc(0, 8'h00, 0, 1);
      cyc(1, 8'h5A, 0, 0);
      cmp++; if (empty !== 1'b0 || rdata !== 8'h5A) begin bad++; $display("FAIL fwft_head got empty=%b rdata=%h exp 0 5a", empty, rdata); end
      cyc(0, 8'h00, 1, 0);
      cmp++; if (empty !== 1'b1 || rdata !== 8'h00) begin bad++; $display("FAIL fwft_pop got empty=%b rdata=%h exp 1 00", empty, rdata); end
   endtask
`endif

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_clear();
      test_async_reset();
`ifdef FIFO_FWFT_EN
      test_fwft();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO, the next generation of the team's FIFO buffering blocks. Configurable data width and power-of-two depth; adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a synchronous flush. Used wherever producer and consumer share one clock, e.g. stream buffering ahead of the dual-clock FIFO stage.

## Interface
- DW, 8, data width in bits (≥1)
- AW, 3, address width; depth = 2**AW (AW ≥ 1)
- AFULL_TH, 6, afull asserts when level ≥ AFULL_TH (1..2**AW)
- AEMPTY_TH, 1, aempty asserts when level ≤ AEMPTY_TH (0..2**AW-1)

- clk  input  1  single clock, rising edge
- rstn  input  1  asynchronous active-low reset
- clr  input  1  synchronous flush
- wreq  input  1  write request
- wdata  input  DW  write data
- full  output  1  no free entry
- afull  output  1  almost full
- rreq  input  1  read request
- rdata  output  DW  read data
- empty  output  1  no stored entry
- aempty  output  1  almost empty
- level  output  AW+1  stored entry count, 0..2**AW
- ovf  output  1  sticky: write attempted while full
- udf  output  1  sticky: read attempted while empty

## Operation
- Storage: 2**AW × DW register array. wr_ptr/rd_ptr are AW+1 bits; low AW bits address, MSB is wrap bit; both increment modulo 2**(AW+1).
- level = wr_ptr − rd_ptr (AW+1-bit modulo subtraction). full = (level == 2**AW); empty = (level == 0).
- Write accepted iff wreq & ~full & ~clr: mem[wr_ptr] ← wdata, wr_ptr+1.
- Read accepted iff rreq & ~empty & ~clr: rd_ptr+1; rdata per Configuration.
- Full/empty gating uses current registered state only: wreq while full is dropped even with a simultaneous accepted read; rreq while empty is dropped even with a simultaneous write.
- Simultaneous accepted read and write: both pointers advance, level unchanged.
- wreq & full & ~clr → ovf ← 1, data dropped, no pointer change. rreq & empty & ~clr → udf ← 1, no pointer change, rdata holds.
- ovf/udf stay set until clr or reset.
- clr: wr_ptr, rd_ptr ← 0, ovf, udf ← 0, rdata ← 0; overrides wreq/rreq that cycle (no ovf/udf set). Memory contents are not cleared.
- Reset (any time, including mid-transfer): pointers 0, ovf=0, udf=0, rdata=0 → empty=1, aempty=1, full=0, afull=0, level=0. Memory contents undefined after reset and never observable.

## Timing
- All outputs are functions of registered state only; no combinational path from wreq/rreq/wdata/clr to any output.
- Status (full, afull, empty, aempty, level) reflects an accepted access on the clock edge that accepts it, i.e. visible in the following cycle.
- Write-to-read: word written at edge N is readable (empty=0) in cycle N+1.
- Standard mode: read latency 1; rdata updates at the accepting edge and holds until the next accepted read, clr or reset.
- Full throughput: one write and one read per cycle sustained.

## Configuration
- FIFO_FWFT_EN defined: first-word fall-through. rdata = mem[rd_ptr] whenever empty=0 (head word visible without request); rdata = 0 when empty=1; rreq pops the head and the next word appears in the following cycle. No rdata register.
- FIFO_FWFT_EN undefined: standard mode, registered rdata as in Operation/Timing.

## Test plan
- Reset then 8 writes 0x00..0x07 (DW=8, AW=3) → level steps 1..8; afull from level 6; full=1 after 8th; 8 reads return 0x00..0x07 in order, empty=1 after last, aempty from level 1.
- Full, wreq with wdata=0xAA → ovf=1, level stays 8, later reads never return 0xAA; ovf persists until clr pulse clears it.
- Empty, rreq → udf=1, rdata unchanged, level 0; rreq+wreq same cycle while empty → write accepted, udf=1, level 1.
- Level 4, simultaneous wreq+rreq for 20 cycles with incrementing data → level stays 4; pointers wrap twice; read sequence continuous, no loss or duplication.
- Level 5 with wreq+rreq+clr asserted → next cycle level 0, empty=1, ovf=udf=0, rdata=0; rstn pulsed low mid-stream → same reset values immediately (asynchronously).
- FIFO_FWFT_EN defined: write 0x5A to empty FIFO → next cycle empty=0, rdata=0x5A without rreq; rreq → next cycle empty=1, rdata=0.
